// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory map bases, bubble encoding, fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] TEXT_BASE_ADDRESS = 32'h0000_3000;
    localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] NOP_INST          = 32'h0000_0000;  // sll $0,$0,0
    localparam int          IM_WORDS_DEFAULT  = 1024;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register holding {pc, inst, valid}; bubble beats hold, reset beats both.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 32'h0;
            r_inst  <= NOP;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            // A bubble still carries the PC it replaced, which helps trace debugging.
            r_pc    <= i_pc;
            r_inst  <= NOP;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch legality check, sticky fault, IF/ID register.
// Optional macro IF_PERF_CNT_EN adds saturating perf_fetch/perf_stall/perf_flush counters.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_ADDRESS,
    parameter int          IM_WORDS  = IM_WORDS_DEFAULT,
    parameter logic [31:0] NOP       = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_inst,
    output logic        ID_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic        dbg_state
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    // Valid/ready note: redirect_valid is a single-cycle command with no back-pressure;
    // the stage always accepts it on the edge where it is high (it overrides stall).

    localparam logic [32:0] TEXT_LO = {1'b0, TEXT_BASE};
    localparam logic [32:0] TEXT_HI = {1'b0, TEXT_BASE} + 33'(IM_WORDS) * 33'd4;

    if_state_t   r_state;
    if_state_t   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_fetch_fault;
    logic [31:0] r_fault_pc;
    logic        w_pc_legal;
    logic        w_fault_evt;
    logic        w_bubble;
    logic        w_load_valid;

    // 33-bit compare so a PC near 2^32 cannot wrap into the legal window.
    assign w_pc_legal = (r_pc[1:0] == 2'b00)
                     && ({1'b0, r_pc} >= TEXT_LO)
                     && ({1'b0, r_pc} <  TEXT_HI);

    assign w_fault_evt  = (r_state == RUN) && !flush && !redirect_valid && !stall && !w_pc_legal;
    assign w_bubble     = flush || redirect_valid
                       || (!stall && ((r_state == FAULT) || !w_pc_legal));
    assign w_load_valid = !w_bubble && !stall;

    always_comb begin
        w_state_next = r_state;
        if (r_state == RUN && w_fault_evt) begin
            w_state_next = FAULT;
        end
    end

    // An illegal PC is held rather than advanced so it is the one reported.
    always_comb begin
        w_pc_next = r_pc;
        if (r_state == RUN) begin
            if (redirect_valid) begin
                w_pc_next = redirect_pc;
            end else if (!stall && w_pc_legal) begin
                w_pc_next = r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= TEXT_BASE;
            r_fetch_fault <= 1'b0;
            r_fault_pc    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fault_evt) begin
                r_fetch_fault <= 1'b1;
                r_fault_pc    <= r_pc;
            end
        end
    end

    if_id_reg #(
        .NOP (NOP)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_stall  (stall),
        .i_bubble (w_bubble),
        .i_pc     (r_pc),
        .i_inst   (imem_rdata),
        .o_pc     (ID_PC),
        .o_inst   (ID_inst),
        .o_valid  (ID_valid)
    );

    assign imem_addr   = r_pc;
    assign IF_PC       = r_pc;
    assign fetch_fault = r_fetch_fault;
    assign fault_pc    = r_fault_pc;
    assign dbg_state   = r_state;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (w_load_valid && r_perf_fetch != 32'hFFFF_FFFF) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (stall && !redirect_valid && r_perf_stall != 32'hFFFF_FFFF) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((flush || redirect_valid) && r_perf_flush != 32'hFFFF_FFFF) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a 4-word ROM model and an ID-output scoreboard.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_inst;
    logic        ID_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic        dbg_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [4];
    logic [64:0] exp_q [$];   // {valid, pc, inst}

    always #5 clk = ~clk;

    if_stage #(
        .IM_WORDS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .IF_PC          (IF_PC),
        .ID_PC          (ID_PC),
        .ID_inst        (ID_inst),
        .ID_valid       (ID_valid),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc),
        .dbg_state      (dbg_state)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch     (perf_fetch),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    // ROM model: legal window 0x3000..0x300C, anything else returns a marker.
    always_comb begin
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_addr[1:0] == 2'b00 && imem_addr >= 32'h3000 && imem_addr < 32'h3010) begin
            imem_rdata = rom[imem_addr[3:2]];
        end
    end

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        return rom[pc[3:2]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] rp);
        stall          = s;
        flush          = f;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_pc(input string name, input logic [31:0] exp);
        n_checks++;
        if (IF_PC !== exp) begin
            n_fail++;
            $display("FAIL %s: IF_PC got %h expected %h", name, IF_PC, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [64:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = exp_q.pop_front();
            if ({ID_valid, ID_PC, ID_inst} !== exp) begin
                n_fail++;
                $display("FAIL %s: ID {valid,pc,inst} got %b %h %h expected %b %h %h",
                         name, ID_valid, ID_PC, ID_inst, exp[64], exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic check_fault(input string name, input logic ef, input logic [31:0] epc);
        n_checks++;
        if (fetch_fault !== ef || fault_pc !== epc) begin
            n_fail++;
            $display("FAIL %s: fault/fault_pc got %b %h expected %b %h",
                     name, fetch_fault, fault_pc, ef, epc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_pc("reset_pc", 32'h3000);
        exp_q.push_back({1'b0, 32'h0, 32'h0});
        sb_check("reset_id");
        check_fault("reset_fault", 1'b0, 32'h0);
        n_checks++;
        if (dbg_state !== 1'b0 || imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL reset_state: state/imem_addr got %b %h expected 0 00003000", dbg_state, imem_addr);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] m_pc;
        do_reset();
        m_pc = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            check_pc("free_pc", m_pc);
            exp_q.push_back({1'b1, m_pc, rom_at(m_pc)});
            step();
            sb_check("free_id");
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        check_pc("stall_pre_pc", 32'h3008);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b1, 32'h3004, rom[1]});
            step();
            check_pc("stall_hold_pc", 32'h3008);
            sb_check("stall_hold_id");
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({1'b1, 32'h3008, rom[2]});
        step();
        check_pc("stall_resume_pc", 32'h300C);
        sb_check("stall_resume_id");
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (perf_stall !== 32'd2 || perf_fetch !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_perf: stall/fetch got %0d %0d expected 2 3", perf_stall, perf_fetch);
        end
`endif
    endtask

    task automatic test_redirect_over_stall();
        do_reset();
        step();
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h3000);
        exp_q.push_back({1'b0, 32'h3008, 32'h0});
        step();
        check_pc("redir_pc", 32'h3000);
        sb_check("redir_bubble");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({1'b1, 32'h3000, rom[0]});
        step();
        check_pc("redir_next_pc", 32'h3004);
        sb_check("redir_target_id");
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (perf_flush !== 32'd1 || perf_stall !== 32'd0) begin
            n_fail++;
            $display("FAIL redir_perf: flush/stall got %0d %0d expected 1 0", perf_flush, perf_stall);
        end
`endif
    endtask

    task automatic test_flush_stall();
        do_reset();
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        exp_q.push_back({1'b0, 32'h3004, 32'h0});
        step();
        check_pc("flush_stall_pc", 32'h3004);
        sb_check("flush_stall_id");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({1'b1, 32'h3004, rom[1]});
        step();
        sb_check("flush_resume_id");
    endtask

    task automatic test_misaligned();
        do_reset();
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h3002);
        step();
        check_pc("mis_pc", 32'h3002);
        check_fault("mis_not_yet", 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_fault("mis_fault", 1'b1, 32'h3002);
        n_checks++;
        if (ID_valid !== 1'b0 || ID_inst !== 32'h0 || dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_bubble: valid/inst/state got %b %h %b expected 0 00000000 1",
                     ID_valid, ID_inst, dbg_state);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h3000);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_pc("mis_frozen_pc", 32'h3002);
        check_fault("mis_sticky", 1'b1, 32'h3002);
        do_reset();
        check_pc("mis_reset_pc", 32'h3000);
        check_fault("mis_reset_fault", 1'b0, 32'h0);
    endtask

    task automatic test_low_boundary();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h2FFC);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_fault("low_bound_fault", 1'b1, 32'h2FFC);
    endtask

    task automatic test_run_off_end();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check_pc("end_pc", 32'h3010);
        check_fault("end_not_yet", 1'b0, 32'h0);
        step();
        check_fault("end_fault", 1'b1, 32'h3010);
        n_checks++;
        if (ID_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL end_bubble: ID_valid got %b expected 0", ID_valid);
        end
        step();
        check_pc("end_frozen_pc", 32'h3010);
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (perf_fetch !== 32'd4) begin
            n_fail++;
            $display("FAIL end_perf_fetch: got %0d expected 4", perf_fetch);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] m_pc;
        logic [64:0] m_id;
        logic        s, f, rv;
        logic [31:0] tgt;
        do_reset();
        m_pc = 32'h3000;
        m_id = {1'b0, 32'h0, 32'h0};
        for (int i = 0; i < 30; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 4) == 0);
            rv  = ($urandom_range(0, 4) == 0);
            if (m_pc == 32'h3010) rv = 1'b1;
            tgt = 32'h3000 + 32'(4 * $urandom_range(0, 3));
            check_pc("b2b_pc", m_pc);
            if (f || rv) begin
                m_id = {1'b0, m_pc, 32'h0};
            end else if (!s) begin
                m_id = {1'b1, m_pc, rom_at(m_pc)};
            end
            exp_q.push_back(m_id);
            if (rv) begin
                m_pc = tgt;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
            drive(s, f, rv, tgt);
            step();
            sb_check("b2b_id");
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check_fault("b2b_no_fault", 1'b0, 32'h0);
    endtask

    initial begin
        rom[0] = 32'h2010_0005;
        rom[1] = 32'h2011_0003;
        rom[2] = 32'h2012_0007;
        rom[3] = 32'h2013_0001;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_over_stall();
        test_flush_stall();
        test_misaligned();
        test_low_boundary();
        test_run_off_end();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-ROM address.
- Accepts stall and flush from the hazard unit, and redirect requests (beq/j/jal/jr) resolved in ID.
- Outputs IF_PC, ID_PC and the ID instruction consumed by decode.
- Also detects out-of-range and misaligned fetch addresses and converts them into a sticky fault plus bubble injection.

Parameters:
- TEXT_BASE, 32'h0000_3000, PC reset value and lowest legal fetch address.
- IM_WORDS, 1024, instruction ROM depth in words; legal range is [TEXT_BASE, TEXT_BASE+4*IM_WORDS).
- NOP_INST, 32'h0000_0000, encoding injected as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  hazard unit: bubble IF/ID next edge.
- redirect_valid  in  1  ID resolved a taken branch or jump.
- redirect_pc  in  32  target address.
- imem_addr  out  32  byte address to ROM; combinational from PC.
- imem_rdata  in  32  ROM data; combinational, same cycle.
- IF_PC  out  32  current PC.
- ID_PC  out  32  PC of instruction in ID.
- ID_inst  out  32  instruction in ID.
- ID_valid  out  1  0 when ID holds a bubble.
- fetch_fault  out  1  sticky: illegal fetch occurred.
- fault_pc  out  32  first offending PC.

Behaviour:
- All state updates on posedge clk. rst is sampled synchronously and has the highest priority.
- Reset values:
  - PC = TEXT_BASE.
  - ID_PC = 0, ID_inst = NOP_INST, ID_valid = 0.
  - fetch_fault = 0, fault_pc = 0.
  - FSM = RUN.
- FSM states: RUN, FAULT. Transitions: RUN->FAULT on an illegal PC; FAULT->RUN only by rst.
- Legal PC: PC[1:0] == 0 and TEXT_BASE <= PC < TEXT_BASE + 4*IM_WORDS. Compare in 33 bits so no wrap at 2^32.
- imem_addr = PC. In FAULT, or for an illegal PC, imem_addr is still driven but imem_rdata is ignored.
- Next-PC priority in RUN:
  1. redirect_valid: PC <= redirect_pc. This overrides stall; the branch in ID is committed.
  2. stall: PC holds.
  3. Otherwise: PC <= PC+4, modulo 2^32.
- IF/ID priority:
  1. flush or redirect_valid: ID_inst <= NOP_INST, ID_valid <= 0, ID_PC <= PC. The delay slot is not executed.
  2. stall: IF/ID holds.
  3. Illegal PC: bubble loaded, fetch_fault <= 1, fault_pc <= PC, FSM -> FAULT.
  4. Otherwise: ID_inst <= imem_rdata, ID_PC <= PC, ID_valid <= 1.
- Combined cases:
  - stall and flush together: flush wins.
  - Redirect to an illegal target: the PC loads, and the fault fires the next cycle when that PC is evaluated.
- FAULT state:
  - PC frozen; IF/ID loads bubbles every cycle (unless stall).
  - fault_pc never overwritten.
- Latency: an instruction appears in ID exactly 1 cycle after its PC is IF_PC, absent stall.
- rst asserted mid-stall or mid-redirect: reset values win on that edge.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_fetch (32): counts cycles loading a valid instruction.
  - perf_stall (32): counts stall cycles that are not redirect cycles.
  - perf_flush (32): counts flush-or-redirect cycles.
- All three counters saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - TEXT_BASE_ADDRESS = 32'h0000_3000 and DATA_BASE_ADDRESS = 32'h0000_0000.
  - NOP_INST.
  - The if_state_t enum (RUN, FAULT).
- One sub-module, if_id_reg: the pipeline register with stall/flush/bubble controls, reusable by the other stage registers.
- PC logic and the legality check stay in if_stage.

Test Plan:
- Reset, then 4 free cycles with ROM = 0x20100005, 0x20110003, ...:
  - IF_PC goes 0x3000, 0x3004, 0x3008, 0x300C.
  - ID_inst = 0x20100005 with ID_PC = 0x3000 one cycle after reset release.
- stall high for 2 cycles at PC 0x3008: IF_PC and ID outputs hold both cycles, then resume at 0x300C.
- redirect_valid with redirect_pc = 0x3000 while stall = 1:
  - Next IF_PC = 0x3000.
  - ID_valid = 0, ID_inst = 0x00000000.
- flush and stall together: next edge gives ID_valid = 0 and PC holds.
- Misaligned redirect to 0x3002:
  - One cycle later: fetch_fault = 1, fault_pc = 0x3002, ID_valid = 0.
  - PC frozen until rst, which clears everything to the reset values.
- Run off the end of the ROM (IM_WORDS = 4): at PC 0x3010 the fault asserts and fault_pc = 0x3010. With IF_PERF_CNT_EN defined, perf_fetch = 4.
